// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: shared FSM encoding and default width for serial arithmetic blocks
package serial_adder_pkg;
    localparam int DEFAULT_WIDTH = 8;
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] FIN  = 2'd2;
endpackage

// File: rtl/FA.sv
// FA: single-bit full-adder cell
module FA (
    output logic sum,
    output logic carry,
    input  logic a,
    input  logic b,
    input  logic cin
);
    assign sum   = a ^ b ^ cin;
    assign carry = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/serial_adder.sv
// serial_adder: bit-serial adder, LSB first, one bit per cycle through a single FA cell
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int CW = $clog2(WIDTH) + 1;
    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_a, r_b, r_sum;
    logic             r_carry;
    logic [CW-1:0]    r_cnt;
    logic             w_s, w_c, w_accept;
    FA u_fa (.sum(w_s), .carry(w_c), .a(r_a[0]), .b(r_b[0]), .cin(r_carry));
    // FIN accepts start just like IDLE so operations can run back-to-back
    assign w_accept = start && (r_state != RUN);
    assign busy     = (r_state == RUN);
    assign done     = (r_state == FIN);
    assign sum      = r_sum;
    assign cout     = r_carry;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
        end else if (w_accept) begin
            r_state <= RUN;
            r_a     <= a;
            r_b     <= b;
            r_carry <= cin;
            r_cnt   <= '0;
        end else if (r_state == RUN) begin
            r_a     <= r_a >> 1;
            r_b     <= r_b >> 1;
            r_sum   <= {w_s, r_sum[WIDTH-1:1]};
            r_carry <= w_c;
            r_cnt   <= r_cnt + CW'(1);
            r_state <= (r_cnt == CW'(WIDTH - 1)) ? FIN : RUN;
        end else begin
            r_state <= IDLE;
        end
    end
endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 WIDTH, default 8, operand and sum width in bits; legal range 2..32.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 start  input  1  request to begin an addition; sampled on rising clk.
REQ-005 a  input  WIDTH  operand A, sampled only on an accepted start.
REQ-006 b  input  WIDTH  operand B, sampled only on an accepted start.
REQ-007 cin  input  1  carry-in, sampled only on an accepted start.
REQ-008 busy  output  1  high while an addition is in progress.
REQ-009 done  output  1  one-cycle pulse; sum/cout valid.
REQ-010 sum  output  WIDTH  result a+b+cin, low WIDTH bits.
REQ-011 cout  output  1  carry-out of the WIDTH-bit addition.

Function
REQ-012 The FSM SHALL have three states: IDLE, RUN, FIN.
REQ-013 IDLE SHALL accept start=1: load a and b into shift registers, load cin into the carry flop, clear the bit counter, and go to RUN.
REQ-014 RUN SHALL process one bit per cycle, LSB first, through one full-adder cell: inputs A[0], B[0], carry flop; the sum bit shifts into the result register MSB; the carry flop takes the cell carry; A and B shift right.
REQ-015 RUN SHALL last exactly WIDTH cycles, with the counter running 0..WIDTH-1; on the last bit it SHALL go to FIN.
REQ-016 FIN SHALL last one cycle with done=1 and then return to IDLE; if start=1 in FIN, it SHALL be accepted as in IDLE (back-to-back operation).
REQ-017 Latency: start sampled at edge k -> done high in the cycle after edge k+WIDTH; one accepted start every WIDTH+1 cycles at most.
REQ-018 busy SHALL be 1 exactly in RUN.
REQ-019 start in RUN SHALL be ignored; operands and the result in flight SHALL be unaffected.
REQ-020 sum and cout SHALL stay stable from done until the next accepted start loads; during RUN they SHALL show the partial shift contents (not valid).
REQ-021 Arithmetic SHALL be modulo 2^WIDTH; cout SHALL equal bit WIDTH of a+b+cin, so all-ones+0+1 gives sum=0, cout=1.
REQ-022 Operand changes on a/b/cin outside an accepted start SHALL have no effect.

Reset
REQ-023 On rst=1, the block SHALL enter IDLE immediately (asynchronously): busy=0, done=0, sum=0, cout=0, counter=0, carry flop=0.
REQ-024 rst asserted mid-RUN SHALL abort the operation; no done pulse SHALL follow.
REQ-025 start SHALL be honoured on the first rising edge after rst deasserts.

Structure
REQ-026 The state encoding (IDLE/RUN/FIN) and the default WIDTH SHALL live in a shared package for reuse by future serial arithmetic blocks.
REQ-027 The per-bit adder SHALL be one instance of the team's existing full-adder cell FA (sum, carry, a, b, cin); no other sub-module.
REQ-028 The counter width SHALL be clog2(WIDTH)+1 bits.

Verification
REQ-029 WIDTH=8: a=0x00, b=0x00, cin=0 -> done after 9 cycles, sum=0x00, cout=0.
REQ-030 WIDTH=8: a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1; and a=0xA5, b=0x5A, cin=1 -> sum=0x00, cout=1.
REQ-031 start pulsed during RUN with different a/b -> ignored; original result delivered; busy high exactly 8 cycles.
REQ-032 rst asserted at RUN cycle 4 -> busy=0 and sum=0 immediately; no done pulse; the next start completes correctly.
REQ-033 Back-to-back: start held high continuously -> done every 9 cycles, each result matching its operands.
REQ-034 WIDTH=3, exhaustive over all 128 (a, b, cin) combinations -> {cout, sum} equals a+b+cin for every case; mismatches are printed as an "A B C | C S" table.
